// File: rtl/window_vote_scanner_pkg.sv
// Shared definitions for the window vote scanner slice.
// Contents:
//   clog2        - constant ceiling-log2 helper for derived widths
//   scan_state_t - controller state encoding (IDLE/SCAN/DRAIN/DONE)
//   DEF_*        - default frame/window geometry shared with image readers
package window_vote_scanner_pkg;

  // Default frame and window geometry.
  localparam int DEF_IMG_W   = 240;
  localparam int DEF_IMG_H   = 180;
  localparam int DEF_WIN     = 3;
  localparam int DEF_STEP    = 1;
  localparam int DEF_RD_LAT  = 1;
  localparam int DEF_COORD_W = 8;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/window_vote_scanner_if.sv
// Control, pixel-read and result bus of the window vote scanner.
// Signals:
//   init/start/pause/thresh   - control from the host
//   rd_en/rd_x/rd_y, pix_in   - pixel RAM read port and returned bit
//   res_*                     - per-window result stream
//   active_count/busy/done    - frame status
// Modports: master = scanner side, slave = host / pixel RAM side.
interface window_vote_scanner_if #(
  parameter int COORD_W = 8,
  parameter int SUM_W   = 4,
  parameter int CNT_W   = 16
);
  logic               init;
  logic               start;
  logic               pause;
  logic [SUM_W-1:0]   thresh;
  logic               rd_en;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               pix_in;
  logic               res_valid;
  logic               res_vote;
  logic [SUM_W-1:0]   res_sum;
  logic [COORD_W-1:0] res_x;
  logic [COORD_W-1:0] res_y;
  logic [CNT_W-1:0]   active_count;
  logic               busy;
  logic               done;

  modport master (
    input  init, start, pause, thresh, pix_in,
    output rd_en, rd_x, rd_y, res_valid, res_vote, res_sum, res_x, res_y,
           active_count, busy, done
  );

  modport slave (
    output init, start, pause, thresh, pix_in,
    input  rd_en, rd_x, rd_y, res_valid, res_vote, res_sum, res_x, res_y,
           active_count, busy, done
  );
endinterface

// File: rtl/window_vote_scanner_addr_gen.sv
// Window address generator: nested cx/cy (inside window) and wx/wy
// (window origin) counters walking the frame row-major.
// Ports:
//   clk, reset      - clock, async active-low reset
//   clear           - synchronous return to the first address
//   advance         - current address is issued this cycle; step on
//   rd_x, rd_y      - current pixel address (wx+cx, wy+cy)
//   win_x, win_y    - origin of the window the current address belongs to
//   last_of_window  - current address is the final pixel of its window
//   last_of_frame   - current address is the final pixel of the frame
module window_vote_scanner_addr_gen
  import window_vote_scanner_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int WIN     = DEF_WIN,
  parameter int STEP    = DEF_STEP,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               last_of_window,
  output logic               last_of_frame
);
  localparam logic [COORD_W-1:0] ZERO_C    = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C     = COORD_W'(1);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] CELL_LAST = COORD_W'(WIN - 1);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - WIN);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - WIN);

  logic [COORD_W-1:0] cx_r;
  logic [COORD_W-1:0] cy_r;
  logic [COORD_W-1:0] wx_r;
  logic [COORD_W-1:0] wy_r;

  // Decode current address and end-of-window/end-of-frame flags.
  always_comb begin
    rd_x           = wx_r + cx_r;
    rd_y           = wy_r + cy_r;
    win_x          = wx_r;
    win_y          = wy_r;
    last_of_window = (cx_r == CELL_LAST) && (cy_r == CELL_LAST);
    last_of_frame  = last_of_window && (wx_r == X_LAST) && (wy_r == Y_LAST);
  end

  // Nested counters; each level wraps and carries into the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_r <= ZERO_C;
      cy_r <= ZERO_C;
      wx_r <= ZERO_C;
      wy_r <= ZERO_C;
    end else if (clear) begin
      cx_r <= ZERO_C;
      cy_r <= ZERO_C;
      wx_r <= ZERO_C;
      wy_r <= ZERO_C;
    end else if (advance) begin
      if (cx_r != CELL_LAST) begin
        cx_r <= cx_r + ONE_C;
      end else begin
        cx_r <= ZERO_C;
        if (cy_r != CELL_LAST) begin
          cy_r <= cy_r + ONE_C;
        end else begin
          cy_r <= ZERO_C;
          if (wx_r != X_LAST) begin
            wx_r <= wx_r + STEP_C;
          end else begin
            wx_r <= ZERO_C;
            if (wy_r != Y_LAST) begin
              wy_r <= wy_r + STEP_C;
            end else begin
              wy_r <= ZERO_C;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/window_vote_scanner.sv
// Window vote scanner: walks a WIN x WIN window over a binary frame held in
// external pixel RAM, sums the returned bits per window and emits a vote
// (sum > thresh) per window, counting the active windows of the frame.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - window_vote_scanner_if.master: init/start/pause/thresh in,
//            rd_en/rd_x/rd_y out, pix_in in, res_* stream out,
//            active_count/busy/done out
module window_vote_scanner
  import window_vote_scanner_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int WIN     = DEF_WIN,
  parameter int STEP    = DEF_STEP,
  parameter int RD_LAT  = DEF_RD_LAT,
  parameter int COORD_W = DEF_COORD_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   reset,
  window_vote_scanner_if.master bus
);
  localparam int SUM_W = clog2(WIN * WIN + 1);
  localparam int DRN_W = clog2(RD_LAT + 1);
  localparam logic [DRN_W-1:0]   DRAIN_LAST = DRN_W'(RD_LAT);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};

  scan_state_t        state_r;
  logic               busy_r;
  logic               done_r;
  logic               rd_en_r;
  logic [COORD_W-1:0] rd_x_r;
  logic [COORD_W-1:0] rd_y_r;
  logic [SUM_W-1:0]   thresh_r;
  logic [DRN_W-1:0]   drain_cnt_r;
  logic [SUM_W-1:0]   acc_r;
  logic               res_valid_r;
  logic               res_vote_r;
  logic [SUM_W-1:0]   res_sum_r;
  logic [COORD_W-1:0] res_x_r;
  logic [COORD_W-1:0] res_y_r;
  logic [CNT_W-1:0]   active_count_r;

  // Tag pipe: stage 0 lines up with the registered read strobe, stage
  // RD_LAT lines up with the returning pixel.
  logic [RD_LAT:0]    tag_valid_r;
  logic [RD_LAT:0]    tag_last_r;
  logic [COORD_W-1:0] tag_wx_r [0:RD_LAT];
  logic [COORD_W-1:0] tag_wy_r [0:RD_LAT];

  logic               start_ok_s;
  logic               issue_s;
  logic               ag_clear_s;
  logic [COORD_W-1:0] ag_x_s;
  logic [COORD_W-1:0] ag_y_s;
  logic [COORD_W-1:0] ag_wx_s;
  logic [COORD_W-1:0] ag_wy_s;
  logic               ag_low_s;
  logic               ag_lof_s;
  logic [SUM_W-1:0]   sum_next_s;
  logic               vote_s;

  // Start acceptance and read issue; init overrides both.
  always_comb begin
    start_ok_s = 1'b0;
    issue_s    = 1'b0;
    if (bus.init) begin
      start_ok_s = 1'b0;
      issue_s    = 1'b0;
    end else begin
      start_ok_s = (state_r == ST_IDLE) && bus.start;
      issue_s    = (state_r == ST_SCAN) && !bus.pause;
    end
  end

  assign ag_clear_s = bus.init | start_ok_s;

  window_vote_scanner_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .WIN     (WIN),
    .STEP    (STEP),
    .COORD_W (COORD_W)
  ) u_addr_gen (
    .clk            (clk),
    .reset          (reset),
    .clear          (ag_clear_s),
    .advance        (issue_s),
    .rd_x           (ag_x_s),
    .rd_y           (ag_y_s),
    .win_x          (ag_wx_s),
    .win_y          (ag_wy_s),
    .last_of_window (ag_low_s),
    .last_of_frame  (ag_lof_s)
  );

  // Running sum including the pixel returning this cycle, and its vote.
  always_comb begin
    sum_next_s = acc_r + SUM_W'(bus.pix_in);
    vote_s     = (sum_next_s > thresh_r);
  end

  // Controller FSM with registered read port and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_x_r      <= COORD_ZERO;
      rd_y_r      <= COORD_ZERO;
      thresh_r    <= {SUM_W{1'b0}};
      drain_cnt_r <= {DRN_W{1'b0}};
    end else if (bus.init) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      drain_cnt_r <= {DRN_W{1'b0}};
    end else begin
      done_r  <= 1'b0;
      rd_en_r <= issue_s;
      if (issue_s) begin
        rd_x_r <= ag_x_s;
        rd_y_r <= ag_y_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_r     <= ST_SCAN;
            busy_r      <= 1'b1;
            thresh_r    <= bus.thresh;
            drain_cnt_r <= {DRN_W{1'b0}};
          end
        end
        ST_SCAN: begin
          if (issue_s && ag_lof_s) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Extra cycle beyond RD_LAT lets the final result register first.
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r <= ST_DONE;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRN_W'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag pipe, accumulator, result stream and saturating active count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_r    <= {(RD_LAT+1){1'b0}};
      tag_last_r     <= {(RD_LAT+1){1'b0}};
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_wx_r[k] <= COORD_ZERO;
        tag_wy_r[k] <= COORD_ZERO;
      end
      acc_r          <= {SUM_W{1'b0}};
      res_valid_r    <= 1'b0;
      res_vote_r     <= 1'b0;
      res_sum_r      <= {SUM_W{1'b0}};
      res_x_r        <= COORD_ZERO;
      res_y_r        <= COORD_ZERO;
      active_count_r <= {CNT_W{1'b0}};
    end else if (bus.init) begin
      // Flush in-flight tags so aborted reads never produce a result.
      tag_valid_r    <= {(RD_LAT+1){1'b0}};
      tag_last_r     <= {(RD_LAT+1){1'b0}};
      acc_r          <= {SUM_W{1'b0}};
      res_valid_r    <= 1'b0;
      active_count_r <= {CNT_W{1'b0}};
    end else begin
      tag_valid_r[0] <= issue_s;
      tag_last_r[0]  <= ag_low_s;
      tag_wx_r[0]    <= ag_wx_s;
      tag_wy_r[0]    <= ag_wy_s;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_valid_r[k] <= tag_valid_r[k-1];
        tag_last_r[k]  <= tag_last_r[k-1];
        tag_wx_r[k]    <= tag_wx_r[k-1];
        tag_wy_r[k]    <= tag_wy_r[k-1];
      end
      res_valid_r <= 1'b0;
      if (start_ok_s) begin
        acc_r          <= {SUM_W{1'b0}};
        active_count_r <= {CNT_W{1'b0}};
      end else if (tag_valid_r[RD_LAT]) begin
        if (tag_last_r[RD_LAT]) begin
          res_valid_r <= 1'b1;
          res_sum_r   <= sum_next_s;
          res_vote_r  <= vote_s;
          res_x_r     <= tag_wx_r[RD_LAT];
          res_y_r     <= tag_wy_r[RD_LAT];
          acc_r       <= {SUM_W{1'b0}};
          if (vote_s && (active_count_r != CNT_MAX)) begin
            active_count_r <= active_count_r + CNT_W'(1);
          end
        end else begin
          acc_r <= sum_next_s;
        end
      end
    end
  end

  assign bus.rd_en        = rd_en_r;
  assign bus.rd_x         = rd_x_r;
  assign bus.rd_y         = rd_y_r;
  assign bus.res_valid    = res_valid_r;
  assign bus.res_vote     = res_vote_r;
  assign bus.res_sum      = res_sum_r;
  assign bus.res_x        = res_x_r;
  assign bus.res_y        = res_y_r;
  assign bus.active_count = active_count_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_window_vote_scanner.sv
// Directed bench for window_vote_scanner.
// Instances: a = 6x5 WIN3 STEP1 RD_LAT2 CNT_W16, b = same with CNT_W3,
//            c = 9x6 WIN3 STEP3 RD_LAT1. sel picks the instance being run.
module tb_window_vote_scanner;
  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic       start;
  logic       pause;
  logic [3:0] thresh;
  int         sel;

  always #5 clk = ~clk;

  window_vote_scanner_if #(.COORD_W(8), .SUM_W(4), .CNT_W(16)) a_if ();
  window_vote_scanner_if #(.COORD_W(8), .SUM_W(4), .CNT_W(3))  b_if ();
  window_vote_scanner_if #(.COORD_W(8), .SUM_W(4), .CNT_W(16)) c_if ();

  window_vote_scanner #(.IMG_W(6), .IMG_H(5), .WIN(3), .STEP(1), .RD_LAT(2),
                        .COORD_W(8), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset), .bus(a_if.master));
  window_vote_scanner #(.IMG_W(6), .IMG_H(5), .WIN(3), .STEP(1), .RD_LAT(2),
                        .COORD_W(8), .CNT_W(3))
    dut_b (.clk(clk), .reset(reset), .bus(b_if.master));
  window_vote_scanner #(.IMG_W(9), .IMG_H(6), .WIN(3), .STEP(3), .RD_LAT(1),
                        .COORD_W(8), .CNT_W(16))
    dut_c (.clk(clk), .reset(reset), .bus(c_if.master));

  assign a_if.init = init;  assign a_if.pause = pause;  assign a_if.thresh = thresh;
  assign b_if.init = init;  assign b_if.pause = pause;  assign b_if.thresh = thresh;
  assign c_if.init = init;  assign c_if.pause = pause;  assign c_if.thresh = thresh;
  assign a_if.start = start && (sel == 0);
  assign b_if.start = start && (sel == 1);
  assign c_if.start = start && (sel == 2);

  // Pixel RAM models with fixed read latency.
  bit         frame [0:63];
  logic [1:0] a_pv = 2'b00, a_pd = 2'b00, b_pv = 2'b00, b_pd = 2'b00;
  logic       c_pv = 1'b0, c_pd = 1'b0;

  always @(posedge clk) begin
    a_pv <= {a_pv[0], a_if.rd_en};
    a_pd <= {a_pd[0], frame[(int'(a_if.rd_y) * 6 + int'(a_if.rd_x)) % 64]};
    b_pv <= {b_pv[0], b_if.rd_en};
    b_pd <= {b_pd[0], frame[(int'(b_if.rd_y) * 6 + int'(b_if.rd_x)) % 64]};
    c_pv <= c_if.rd_en;
    c_pd <= frame[(int'(c_if.rd_y) * 9 + int'(c_if.rd_x)) % 64];
  end

  assign a_if.pix_in = a_pv[1] & a_pd[1];
  assign b_if.pix_in = b_pv[1] & b_pd[1];
  assign c_if.pix_in = c_pv & c_pd;

  // Observed signals of the selected instance.
  logic m_rv, m_rd, m_dn, m_vote, m_busy;
  int   m_x, m_y, m_s, m_cnt;
  always_comb begin
    m_rv = a_if.res_valid; m_rd = a_if.rd_en; m_dn = a_if.done;
    m_vote = a_if.res_vote; m_busy = a_if.busy;
    m_x = int'(a_if.res_x); m_y = int'(a_if.res_y);
    m_s = int'(a_if.res_sum); m_cnt = int'(a_if.active_count);
    if (sel == 1) begin
      m_rv = b_if.res_valid; m_rd = b_if.rd_en; m_dn = b_if.done;
      m_vote = b_if.res_vote; m_busy = b_if.busy;
      m_x = int'(b_if.res_x); m_y = int'(b_if.res_y);
      m_s = int'(b_if.res_sum); m_cnt = int'(b_if.active_count);
    end else if (sel == 2) begin
      m_rv = c_if.res_valid; m_rd = c_if.rd_en; m_dn = c_if.done;
      m_vote = c_if.res_vote; m_busy = c_if.busy;
      m_x = int'(c_if.res_x); m_y = int'(c_if.res_y);
      m_s = int'(c_if.res_sum); m_cnt = int'(c_if.active_count);
    end
  end

  // Monitor on the falling edge: monotonic counters and result queues.
  int cyc = 0;
  int rd_cnt = 0, done_cnt = 0, last_rd_cyc = 0, last_res_cyc = 0, done_cyc = 0;
  int rq_x[$], rq_y[$], rq_s[$], rq_v[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_rd) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
    end
    if (m_rv) begin
      rq_x.push_back(m_x);
      rq_y.push_back(m_y);
      rq_s.push_back(m_s);
      rq_v.push_back(int'(m_vote));
      last_res_cyc <= cyc;
    end
    if (m_dn) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int errors = 0;
  int checks = 0;
  int rd_base, res_base, done_base;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: all ones; 1: single 1 at (2,2) of a 6-wide frame; 2: 9-wide checkerboard.
  task automatic fill(input int mode);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0) frame[i] = 1'b1;
      else if (mode == 1) frame[i] = (i == 14);
      else frame[i] = (((i % 9) + (i / 9)) % 2 == 0);
    end
  endtask

  function automatic int ref_sum(input int wx, input int wy, input int w);
    int s;
    s = 0;
    for (int cy = 0; cy < 3; cy++)
      for (int cx = 0; cx < 3; cx++)
        s += int'(frame[(wy + cy) * w + wx + cx]);
    return s;
  endfunction

  // Pulse start on the selected instance and run until done (bounded).
  task automatic run_frame(input int budget, input bit pause_mode, input int inject_at);
    int k;
    bit finished;
    rd_base = rd_cnt; res_base = rq_x.size(); done_base = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    finished = 1'b0;
    while (!finished && k < budget) begin
      pause = pause_mode && (k % 3 == 2);
      start = (k == inject_at);
      if (k == inject_at) thresh = 4'd15;
      @(posedge clk); #1;
      k++;
      finished = (done_cnt != done_base);
    end
    pause = 1'b0;
    start = 1'b0;
    check("frame_done_seen", int'(finished), 1);
  endtask

  // Compare the captured frame against the reference walk of window origins.
  task automatic check_frame(input int w, input int h, input int st, input int lat,
                             input int thr, input int exp_cnt);
    int n, s;
    n = 0;
    for (int wy = 0; wy <= h - 3; wy += st) begin
      for (int wx = 0; wx <= w - 3; wx += st) begin
        s = ref_sum(wx, wy, w);
        if (res_base + n < rq_x.size()) begin
          check("res_x", rq_x[res_base + n], wx);
          check("res_y", rq_y[res_base + n], wy);
          check("res_sum", rq_s[res_base + n], s);
          check("res_vote", rq_v[res_base + n], int'(s > thr));
        end else begin
          check("res_present", rq_x.size() - res_base, n + 1);
        end
        n++;
      end
    end
    check("res_count", rq_x.size() - res_base, n);
    check("rd_count", rd_cnt - rd_base, n * 9);
    check("active_count", m_cnt, exp_cnt);
    check("busy_after_done", int'(m_busy), 0);
    check("result_latency", last_res_cyc - last_rd_cyc, lat + 1);
    check("done_after_last_res", done_cyc - last_res_cyc, 1);
  endtask

  initial begin
    int k, snap_res, snap_done;
    reset = 1'b0; init = 1'b0; start = 1'b0; pause = 1'b0; thresh = 4'd0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(a_if.busy), 0);
    check("reset_done", int'(a_if.done), 0);
    check("reset_rd_en", int'(a_if.rd_en), 0);
    check("reset_res_valid", int'(a_if.res_valid), 0);
    check("reset_active_count", int'(a_if.active_count), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // All-ones frame, thresh 4: every window sums 9 and votes.
    fill(0); thresh = 4'd4;
    run_frame(400, 1'b0, -1);
    check_frame(6, 5, 1, 2, 4, 12);

    // Single set pixel at (2,2), thresh 0: only origins with wx<=2 vote.
    fill(1); thresh = 4'd0;
    run_frame(400, 1'b0, -1);
    check_frame(6, 5, 1, 2, 0, 9);

    // Pause every third cycle: same results, same read count.
    fill(0); thresh = 4'd4;
    run_frame(800, 1'b1, -1);
    check_frame(6, 5, 1, 2, 4, 12);

    // Threshold at WIN*WIN: no window can vote.
    thresh = 4'd9;
    run_frame(400, 1'b0, -1);
    check_frame(6, 5, 1, 2, 9, 0);

    // init in the middle of window 5 aborts the frame.
    thresh = 4'd4;
    rd_base = rd_cnt; done_base = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while ((rd_cnt - rd_base) < 40 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("init_reached_window5", int'((rd_cnt - rd_base) >= 40), 1);
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    snap_res = rq_x.size();
    snap_done = done_cnt;
    check("init_busy", int'(a_if.busy), 0);
    check("init_active_count", int'(a_if.active_count), 0);
    check("init_rd_en", int'(a_if.rd_en), 0);
    repeat (10) @(posedge clk);
    #1;
    check("init_no_result", rq_x.size() - snap_res, 0);
    check("init_no_done", done_cnt - snap_done, 0);
    run_frame(400, 1'b0, -1);
    check_frame(6, 5, 1, 2, 4, 12);

    // Narrow count saturates; start and thresh changes mid-frame are ignored.
    sel = 1;
    fill(0); thresh = 4'd0;
    run_frame(400, 1'b0, 20);
    check_frame(6, 5, 1, 2, 0, 7);

    // Stride 3 over a 9x6 checkerboard, read latency 1.
    sel = 2;
    fill(2); thresh = 4'd4;
    run_frame(400, 1'b0, -1);
    check_frame(9, 6, 3, 1, 4, 3);

    // Asynchronous reset in the middle of a frame clears outputs at once.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre_reset_busy", int'(c_if.busy), 1);
    reset = 1'b0;
    #1;
    check("async_busy", int'(c_if.busy), 0);
    check("async_rd_en", int'(c_if.rd_en), 0);
    check("async_res_valid", int'(c_if.res_valid), 0);
    check("async_done", int'(c_if.done), 0);
    check("async_active_count", int'(c_if.active_count), 0);
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    run_frame(400, 1'b0, -1);
    check_frame(9, 6, 3, 1, 4, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
